game_ctrl: RTL and testbench

//  Parametrised game-state controller for the PacMan datapath. It detects collisions

---
 rtl/game_pkg.sv | 22 ++
 rtl/ghost_collide.sv | 27 ++
 rtl/game_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding and arithmetic helpers for the PacMan game-state controller.
package game_pkg;

    typedef enum logic [2:0] {
        RESTART   = 3'd0,
        PAUSE     = 3'd1,
        RUN       = 3'd2,
        LIFE_DOWN = 3'd3,
        LIFE_HOLD = 3'd4,
        GAME_OVER = 3'd5,
        GAME_WON  = 3'd6
    } state_t;

    localparam int ABS_W  = 32;
    localparam int HOLD_W = 16;

    function automatic logic [ABS_W-1:0] absdiff(input logic [ABS_W-1:0] a,
                                                 input logic [ABS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ghost_collide.sv
// Box-overlap test between PacMan and one ghost, with a small pixel tolerance.
module ghost_collide
    import game_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int TOL     = 2
) (
    input  logic [COORD_W-1:0] pX,
    input  logic [COORD_W-1:0] pY,
    input  logic [COORD_W-1:0] gX,
    input  logic [COORD_W-1:0] gY,
    input  logic [COORD_W-1:0] pSize,
    input  logic [COORD_W-1:0] gSize,
    output logic               hit
);

    logic [COORD_W+1:0] reach;
    logic [ABS_W-1:0]   dx;
    logic [ABS_W-1:0]   dy;

    // Two extra bits keep the sum of two full-range half-extents plus tolerance from wrapping.
    assign reach = (COORD_W+2)'(pSize) + (COORD_W+2)'(gSize) + (COORD_W+2)'(TOL);
    assign dx    = absdiff(ABS_W'(pX), ABS_W'(gX));
    assign dy    = absdiff(ABS_W'(pY), ABS_W'(gY));
    assign hit   = (dx <= ABS_W'(reach)) && (dy <= ABS_W'(reach));

endmodule

// File: rtl/game_ctrl.sv
// PacMan game-state controller: collisions, score/lives/fruit bookkeeping and
// the start/run/life-loss/win/lose sequencing with a timed frightened mode.
module game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_GHOSTS = 3,
    parameter int NUM_FRUITS = 4,
    parameter int COORD_W    = 10,
    parameter int SCORE_W    = 10,
    parameter int LIVES      = 3,
    parameter int TOL        = 2,
    parameter int FRUIT_PTS  = 50,
    parameter int GHOST_PTS  = 100,
    parameter int FRIGHT_CYC = 600,
    parameter int HOLD_MIN   = 60
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          start,
    input  logic                          timer_expired,
    input  logic                          dots_done,
    input  logic                          power_pellet,
    input  logic [NUM_FRUITS-1:0]         fruit_hit,
    input  logic [COORD_W-1:0]            pX,
    input  logic [COORD_W-1:0]            pY,
    input  logic [NUM_GHOSTS*COORD_W-1:0] gX,
    input  logic [NUM_GHOSTS*COORD_W-1:0] gY,
    input  logic [COORD_W-1:0]            pSize,
    input  logic [COORD_W-1:0]            gSize,
    output state_t                        state,
    output logic                          pause,
    output logic                          win,
    output logic                          lose,
    output logic                          lifeDown,
    output logic                          frightened,
    output logic [NUM_GHOSTS-1:0]         ghost_eaten,
    output logic [SCORE_W-1:0]            score,
    output logic [3:0]                    lives,
    output logic [NUM_FRUITS-1:0]         fruits_eaten
);

    localparam int                 TMR_W     = $clog2(FRIGHT_CYC + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t                  state_d;
    logic [NUM_GHOSTS-1:0]   hit;
    logic [NUM_GHOSTS-1:0]   eat_sel;
    logic [NUM_FRUITS-1:0]   fruit_avail;
    logic [NUM_FRUITS-1:0]   fruit_sel;
    logic [TMR_W-1:0]        fright_timer;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    any_hit;
    logic                    in_play;
    logic                    do_eat;
    logic                    do_fruit;
    logic [31:0]             score_sum;
    logic [SCORE_W-1:0]      score_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_collide
            ghost_collide #(
                .COORD_W(COORD_W),
                .TOL    (TOL)
            ) u_collide (
                .pX   (pX),
                .pY   (pY),
                .gX   (gX[gi*COORD_W +: COORD_W]),
                .gY   (gY[gi*COORD_W +: COORD_W]),
                .pSize(pSize),
                .gSize(gSize),
                .hit  (hit[gi])
            );
        end
    endgenerate

    assign any_hit     = |hit;
    assign frightened  = (fright_timer != '0);
    assign fruit_avail = fruit_hit & ~fruits_eaten;

    always_comb begin
        eat_sel = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                eat_sel    = '0;
                eat_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        fruit_sel = '0;
        for (int j = NUM_FRUITS - 1; j >= 0; j--) begin
            if (fruit_avail[j]) begin
                fruit_sel    = '0;
                fruit_sel[j] = 1'b1;
            end
        end
    end

    // Eating and fruit only happen when no higher-priority RUN exit fires this cycle.
    assign in_play  = (state == RUN) && !timer_expired && !dots_done;
    assign do_eat   = in_play && any_hit && frightened;
    assign do_fruit = in_play && !any_hit && (|fruit_avail);

    assign score_sum  = 32'(score) + (do_eat ? 32'(GHOST_PTS) : 32'(FRUIT_PTS));
    assign score_next = (score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RESTART;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            RESTART:   state_d = PAUSE;
            PAUSE:     if (start) state_d = RUN;
            RUN: begin
                if (timer_expired)              state_d = GAME_OVER;
                else if (dots_done)             state_d = GAME_WON;
                else if (any_hit && !frightened) state_d = LIFE_DOWN;
            end
            LIFE_DOWN: state_d = (lives <= 4'd1) ? GAME_OVER : LIFE_HOLD;
            LIFE_HOLD: begin
                if (!any_hit && (hold_cnt >= HOLD_W'(HOLD_MIN - 1))) state_d = RUN;
            end
            GAME_OVER, GAME_WON: if (start) state_d = RESTART;
            default:   state_d = RESTART;
        endcase
    end

    always_comb begin
        pause    = 1'b0;
        win      = 1'b0;
        lose     = 1'b0;
        lifeDown = 1'b0;
        case (state)
            PAUSE:     pause = 1'b1;
            LIFE_DOWN, LIFE_HOLD: lifeDown = 1'b1;
            GAME_OVER: begin
                lose  = 1'b1;
                pause = 1'b1;
            end
            GAME_WON: begin
                win   = 1'b1;
                pause = 1'b1;
            end
            default: ;
        endcase
    end

    // A power pellet always reloads the timer, even in the cycle it would otherwise be cleared.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score        <= '0;
            lives        <= 4'(LIVES);
            fruits_eaten <= '0;
            fright_timer <= '0;
            hold_cnt     <= '0;
            ghost_eaten  <= '0;
        end else begin
            ghost_eaten <= do_eat ? eat_sel : '0;

            if (state == RESTART) begin
                score        <= '0;
                lives        <= 4'(LIVES);
                fruits_eaten <= '0;
            end else if (do_eat) begin
                score <= score_next;
            end else if (do_fruit) begin
                score        <= score_next;
                fruits_eaten <= fruits_eaten | fruit_sel;
            end else if (state == LIFE_DOWN && lives != 4'd0) begin
                lives <= lives - 4'd1;
            end

            if (state == LIFE_HOLD && state_d == LIFE_HOLD) begin
                if (hold_cnt != '1) hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end

            if (power_pellet) begin
                fright_timer <= TMR_W'(FRIGHT_CYC);
            end else if (state == RESTART) begin
                fright_timer <= '0;
            end else if (state == RUN && state_d == LIFE_DOWN) begin
                fright_timer <= '0;
            end else if (state == RUN && fright_timer != '0) begin
                fright_timer <= fright_timer - TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios, a collision vector table
// and a randomized run against a behavioural model of the game rules.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int NG = 3;
    localparam int NF = 4;
    localparam int CW = 10;
    localparam int SMAX = 1023;
    localparam int LIVES0 = 3;
    localparam int TOLV = 2;
    localparam int FRIGHT = 600;
    localparam int HOLDMIN = 60;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic           start = 1'b0;
    logic           timer_expired = 1'b0;
    logic           dots_done = 1'b0;
    logic           power_pellet = 1'b0;
    logic [NF-1:0]  fruit_hit = '0;
    logic [CW-1:0]  pX = '0;
    logic [CW-1:0]  pY = '0;
    logic [NG*CW-1:0] gX = '0;
    logic [NG*CW-1:0] gY = '0;
    logic [CW-1:0]  pSize = '0;
    logic [CW-1:0]  gSize = '0;
    state_t         state;
    logic           pause, win, lose, lifeDown, frightened;
    logic [NG-1:0]  ghost_eaten;
    logic [9:0]     score;
    logic [3:0]     lives;
    logic [NF-1:0]  fruits_eaten;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    game_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .timer_expired(timer_expired),
        .dots_done(dots_done), .power_pellet(power_pellet), .fruit_hit(fruit_hit),
        .pX(pX), .pY(pY), .gX(gX), .gY(gY), .pSize(pSize), .gSize(gSize),
        .state(state), .pause(pause), .win(win), .lose(lose), .lifeDown(lifeDown),
        .frightened(frightened), .ghost_eaten(ghost_eaten), .score(score),
        .lives(lives), .fruits_eaten(fruits_eaten)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        int px, py, psz, gsz;
        int g0x, g0y, g1x, g1y, g2x, g2y;
        logic [2:0] eaten;
    } vec_t;

    vec_t vecs[12];

    // Behavioural model state
    state_t     m_state;
    int         m_score, m_lives, m_timer, m_hold;
    logic [3:0] m_fruits;
    logic [2:0] m_eaten;

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        cyc++;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        gX[i*CW +: CW] = CW'(x);
        gY[i*CW +: CW] = CW'(y);
    endtask

    task automatic set_far();
        set_ghost(0, 100, 100);
        set_ghost(1, 800, 100);
        set_ghost(2, 100, 800);
    endtask

    task automatic restart_to_run();
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        check_output("restart to RUN", 32'(state), 32'(RUN));
    endtask

    task automatic hold_exit_count(input string name, input int expected);
        int n = 0;
        while (state == LIFE_HOLD && n < 200) begin
            tick();
            n++;
        end
        check_output(name, 32'(n), 32'(expected));
        check_output({name, " state"}, 32'(state), 32'(RUN));
    endtask

    function automatic bit model_hit(input int i);
        int dx, dy, reach;
        dx = int'(pX) - int'(gX[i*CW +: CW]);
        dy = int'(pY) - int'(gY[i*CW +: CW]);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        reach = int'(pSize) + int'(gSize) + TOLV;
        return (dx <= reach) && (dy <= reach);
    endfunction

    task automatic model_reset();
        m_state = RESTART; m_score = 0; m_lives = LIVES0; m_timer = 0; m_hold = 0;
        m_fruits = '0; m_eaten = '0;
    endtask

    task automatic model_step();
        int     first = -1;
        bit     scared = (m_timer > 0);
        bit     clear_t = 0;
        state_t was = m_state;
        for (int i = 0; i < NG; i++) if (model_hit(i) && first < 0) first = i;
        m_eaten = '0;
        case (m_state)
            RESTART: begin
                m_score = 0; m_lives = LIVES0; m_fruits = '0; clear_t = 1; m_state = PAUSE;
            end
            PAUSE: if (start) m_state = RUN;
            RUN: begin
                if (timer_expired) m_state = GAME_OVER;
                else if (dots_done) m_state = GAME_WON;
                else if (first >= 0 && !scared) begin
                    m_state = LIFE_DOWN; clear_t = 1;
                end else if (first >= 0) begin
                    m_eaten[first] = 1'b1;
                    m_score = (m_score + 100 > SMAX) ? SMAX : m_score + 100;
                end else begin
                    for (int j = 0; j < NF; j++) begin
                        if (fruit_hit[j] && !m_fruits[j]) begin
                            m_fruits[j] = 1'b1;
                            m_score = (m_score + 50 > SMAX) ? SMAX : m_score + 50;
                            break;
                        end
                    end
                end
            end
            LIFE_DOWN: begin
                m_state = (m_lives <= 1) ? GAME_OVER : LIFE_HOLD;
                if (m_lives > 0) m_lives--;
            end
            LIFE_HOLD: begin
                if (first < 0 && m_hold >= HOLDMIN - 1) begin
                    m_state = RUN; m_hold = 0;
                end else m_hold++;
            end
            default: if (start) m_state = RESTART;
        endcase
        if (power_pellet) m_timer = FRIGHT;
        else if (clear_t) m_timer = 0;
        else if (was == RUN && m_timer > 0) m_timer--;
    endtask

    task automatic apply_stimulus();
        start         = ($urandom_range(0, 7) == 0);
        timer_expired = ($urandom_range(0, 299) == 0);
        dots_done     = ($urandom_range(0, 299) == 0);
        power_pellet  = ($urandom_range(0, 59) == 0);
        fruit_hit     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        pX    = CW'($urandom_range(0, 1023));
        pY    = CW'($urandom_range(0, 1023));
        pSize = CW'($urandom_range(0, 10));
        gSize = CW'($urandom_range(0, 10));
        for (int i = 0; i < NG; i++) begin
            if ($urandom_range(0, 11) == 0)
                set_ghost(i, int'(pX) + int'($urandom_range(0, 50)) - 25,
                          int'(pY) + int'($urandom_range(0, 50)) - 25);
            else
                set_ghost(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
    endtask

    task automatic check_model(input int k);
        logic e_pause, e_win, e_lose, e_ld;
        logic [31:0] got, want;
        e_pause = (m_state == PAUSE) || (m_state == GAME_OVER) || (m_state == GAME_WON);
        e_win   = (m_state == GAME_WON);
        e_lose  = (m_state == GAME_OVER);
        e_ld    = (m_state == LIFE_DOWN) || (m_state == LIFE_HOLD);
        got  = {3'(state), score, lives, fruits_eaten, ghost_eaten, frightened,
                pause, win, lose, lifeDown};
        want = {3'(m_state), 10'(m_score), 4'(m_lives), m_fruits, m_eaten, (m_timer > 0),
                e_pause, e_win, e_lose, e_ld};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL random cycle %0d: got st=%0d sc=%0d lv=%0d fr=%b ge=%b fm=%b fl=%b%b%b%b, expected st=%0d sc=%0d lv=%0d fr=%b ge=%b fm=%b fl=%b%b%b%b",
                     k, state, score, lives, fruits_eaten, ghost_eaten, frightened,
                     pause, win, lose, lifeDown, m_state, m_score, m_lives, m_fruits,
                     m_eaten, (m_timer > 0), e_pause, e_win, e_lose, e_ld);
        end
    endtask

    initial begin
        int exp_score;
        int pellet_cyc;
        int n;

        vecs[0]  = '{500, 500, 8, 8, 100, 100, 518, 500, 100, 800, 3'b010};
        vecs[1]  = '{500, 500, 8, 8, 100, 100, 519, 500, 100, 800, 3'b000};
        vecs[2]  = '{500, 500, 8, 8, 100, 100, 800, 100, 500, 482, 3'b100};
        vecs[3]  = '{500, 500, 8, 8, 100, 100, 800, 100, 481, 500, 3'b000};
        vecs[4]  = '{500, 500, 8, 8, 510, 490, 500, 500, 100, 800, 3'b001};
        vecs[5]  = '{500, 500, 8, 8, 100, 100, 505, 505, 495, 495, 3'b010};
        vecs[6]  = '{500, 500, 8, 8, 518, 519, 800, 100, 100, 800, 3'b000};
        vecs[7]  = '{0, 0, 8, 8, 1023, 0, 800, 100, 100, 800, 3'b000};
        vecs[8]  = '{1023, 1023, 8, 8, 100, 100, 800, 100, 1010, 1010, 3'b100};
        vecs[9]  = '{0, 0, 1023, 1023, 1023, 1023, 800, 100, 100, 800, 3'b001};
        vecs[10] = '{300, 300, 0, 0, 100, 100, 302, 298, 100, 800, 3'b010};
        vecs[11] = '{300, 300, 0, 0, 100, 100, 303, 300, 100, 800, 3'b000};

        pX = 500; pY = 500; pSize = 8; gSize = 8;
        set_far();

        // Reset state
        tick(); tick();
        check_output("reset state", 32'(state), 32'(RESTART));
        check_output("reset score", 32'(score), 0);
        check_output("reset lives", 32'(lives), 3);
        check_output("reset fruits", 32'(fruits_eaten), 0);
        check_output("reset frightened", 32'(frightened), 0);
        check_output("reset ghost_eaten", 32'(ghost_eaten), 0);
        Reset_n = 1'b1;
        tick();
        check_output("after reset state", 32'(state), 32'(PAUSE));
        check_output("pause flag", 32'(pause), 1);

        // First life loss; ghost keeps overlapping during the hold
        start = 1'b1; tick(); start = 1'b0;
        check_output("start state", 32'(state), 32'(RUN));
        set_ghost(1, 505, 500);
        tick();
        check_output("hit1 state", 32'(state), 32'(LIFE_DOWN));
        check_output("hit1 lifeDown", 32'(lifeDown), 1);
        tick();
        check_output("hold1 state", 32'(state), 32'(LIFE_HOLD));
        check_output("hold1 lives", 32'(lives), 2);
        for (int i = 0; i < 80; i++) tick();
        check_output("hold while overlapping", 32'(state), 32'(LIFE_HOLD));
        set_far();
        tick();
        check_output("resume after separation", 32'(state), 32'(RUN));

        // Second and third life losses
        set_ghost(1, 505, 500);
        tick();
        check_output("hit2 state", 32'(state), 32'(LIFE_DOWN));
        tick();
        set_far();
        check_output("hit2 lives", 32'(lives), 1);
        hold_exit_count("hold2 cycles", HOLDMIN);
        set_ghost(0, 500, 510);
        tick();
        check_output("hit3 state", 32'(state), 32'(LIFE_DOWN));
        tick();
        set_far();
        check_output("hit3 state", 32'(state), 32'(GAME_OVER));
        check_output("hit3 lives", 32'(lives), 0);
        check_output("hit3 lose", 32'(lose), 1);
        check_output("hit3 pause", 32'(pause), 1);
        tick(); tick();
        check_output("game over sticky", 32'(state), 32'(GAME_OVER));
        start = 1'b1; tick(); start = 1'b0;
        check_output("over to restart", 32'(state), 32'(RESTART));
        tick();
        check_output("restart lives", 32'(lives), 3);
        check_output("restart to pause", 32'(state), 32'(PAUSE));

        // Timer expiry beats dots done; dots done alone wins
        start = 1'b1; tick(); start = 1'b0;
        timer_expired = 1'b1; dots_done = 1'b1;
        tick();
        timer_expired = 1'b0; dots_done = 1'b0;
        check_output("expire+dots state", 32'(state), 32'(GAME_OVER));
        check_output("expire+dots win", 32'(win), 0);
        restart_to_run();
        dots_done = 1'b1; tick(); dots_done = 1'b0;
        check_output("dots state", 32'(state), 32'(GAME_WON));
        check_output("dots win", 32'(win), 1);
        restart_to_run();

        // Frightened eats, lowest index first
        power_pellet = 1'b1; tick(); power_pellet = 1'b0;
        pellet_cyc = cyc;
        check_output("pellet frightened", 32'(frightened), 1);
        set_ghost(0, 500, 500);
        set_ghost(2, 490, 500);
        tick();
        check_output("eat first", 32'(ghost_eaten), 32'(3'b001));
        check_output("eat first score", 32'(score), 100);
        set_ghost(0, 100, 100);
        tick();
        check_output("eat second", 32'(ghost_eaten), 32'(3'b100));
        check_output("eat second score", 32'(score), 200);
        set_far();
        tick();
        check_output("eat done", 32'(ghost_eaten), 0);
        check_output("eat lives", 32'(lives), 3);
        exp_score = 200;

        // Collision geometry table, evaluated while frightened
        for (int i = 0; i < 12; i++) begin
            pX = CW'(vecs[i].px); pY = CW'(vecs[i].py);
            pSize = CW'(vecs[i].psz); gSize = CW'(vecs[i].gsz);
            set_ghost(0, vecs[i].g0x, vecs[i].g0y);
            set_ghost(1, vecs[i].g1x, vecs[i].g1y);
            set_ghost(2, vecs[i].g2x, vecs[i].g2y);
            tick();
            if (vecs[i].eaten != 3'b000) exp_score += 100;
            check_output($sformatf("vec%0d eaten", i), 32'(ghost_eaten), 32'(vecs[i].eaten));
            check_output($sformatf("vec%0d score", i), 32'(score), 32'(exp_score));
            check_output($sformatf("vec%0d state", i), 32'(state), 32'(RUN));
        end

        // Frightened mode lasts exactly FRIGHT RUN cycles
        pX = 500; pY = 500; pSize = 8; gSize = 8;
        set_far();
        n = 0;
        while (frightened && n < 1000) begin
            tick();
            n++;
        end
        check_output("fright duration", 32'(cyc - pellet_cyc), 32'(FRIGHT));

        // Fruits: each counted once, then saturation
        fruit_hit = 4'b0011;
        tick();
        check_output("fruit1 bits", 32'(fruits_eaten), 32'(4'b0001));
        check_output("fruit1 score", 32'(score), 950);
        tick();
        check_output("fruit2 bits", 32'(fruits_eaten), 32'(4'b0011));
        check_output("fruit2 score", 32'(score), 1000);
        tick();
        check_output("fruit repeat score", 32'(score), 1000);
        fruit_hit = 4'b0100;
        tick();
        check_output("fruit sat score", 32'(score), SMAX);
        fruit_hit = 4'b1000;
        tick();
        check_output("fruit sat bits", 32'(fruits_eaten), 32'(4'b1111));
        check_output("fruit sat hold", 32'(score), SMAX);
        fruit_hit = '0;

        // Asynchronous reset in the middle of RUN
        timer_expired = 1'b1; tick(); timer_expired = 1'b0;
        restart_to_run();
        power_pellet = 1'b1; tick(); power_pellet = 1'b0;
        set_ghost(0, 500, 500);
        tick();
        set_far();
        fruit_hit = 4'b0001;
        tick();
        fruit_hit = '0;
        check_output("pre-reset score", 32'(score), 150);
        #2 Reset_n = 1'b0;
        #1;
        check_output("async reset state", 32'(state), 32'(RESTART));
        check_output("async reset score", 32'(score), 0);
        check_output("async reset lives", 32'(lives), 3);
        check_output("async reset frightened", 32'(frightened), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        check_output("post reset state", 32'(state), 32'(PAUSE));

        // Randomized run against the model
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4000; k++) begin
            apply_stimulus();
            model_step();
            tick();
            check_model(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
